ram16_access_ctrl: RTL
======================

Name: ram16_access_ctrl

Overview:
- Request-side controller that sits directly upstream of the 16-bit byte-addressable RAM block. It converts CPU load/store requests (byte or word, any byte address) into RAM transactions.
- The RAM always writes two bytes, at addr and addr+1. This block therefore performs read-modify-write for byte stores, so the neighbouring byte is preserved.
- It returns load data through a valid/ready request and response handshake.

Parameters:
addrSize, 9, RAM byte-address width; must match the downstream RAM instance.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  1  0 = byte, 1 = word (16-bit, little-endian)
req_addr  in  addrSize  byte address
req_wdata  in  16  store data; byte store uses [7:0]
resp_valid  out  1  one-cycle pulse: request completed
resp_rdata  out  16  load data; byte load is zero-extended; 0 for stores
ram_addr  out  addrSize  to RAM addr
ram_wdata  out  16  to RAM data_in
ram_write_rq  out  1  to RAM write_rq
ram_output_en  out  1  to RAM output_en
ram_rdata  in  16  from RAM data_out (combinational read of {mem[addr+1], mem[addr]})

Behaviour:
- Reset (reset low, async):
  - state = IDLE.
  - req_ready, resp_valid, ram_write_rq and ram_output_en are all 0.
  - ram_addr = 0, ram_wdata = 0, resp_rdata = 0, latched request = 0.
  - While reset is held low, req_ready stays 0.
- States: IDLE, ACCESS, MERGE, RESP. ram_* outputs are registered or decoded from state and latched request only; there is no combinational path from req_* to ram_*.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at a rising edge: latch addr, we, size and wdata, then go to ACCESS.
  - Requests while not in IDLE are ignored; the CPU holds req_valid.
- ACCESS:
  - ram_addr = latched addr; ram_output_en = 1.
  - Load: capture resp_rdata = size ? ram_rdata : {8'h00, ram_rdata[7:0]}, then go to RESP.
  - Word store: ram_write_rq = 1, ram_wdata = latched wdata, then go to RESP.
  - Byte store: capture old = ram_rdata, then go to MERGE; no write is issued in this state.
- MERGE (byte store only):
  - ram_output_en = 1, ram_write_rq = 1.
  - ram_wdata = {old[15:8], wdata[7:0]}, so mem[addr+1] is rewritten with its own value.
  - Then go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_rdata holds the load result; it is 0 for stores.
  - Next state is IDLE.
  - resp_rdata holds its value until the next load completes.
- Latency from accept edge to resp_valid high:
  - loads and word stores: 2 cycles;
  - byte stores: 3 cycles.
  - Back-to-back throughput: one request per 3 cycles, or 4 for byte stores.
- ram_write_rq is asserted for exactly one cycle per store and never for loads.
- Addresses:
  - Any byte address is legal, including odd ones.
  - At addr = 2**addrSize-1 the upper byte wraps to address 0; this is RAM behaviour and the controller does no alignment checking.
- Reset mid-operation:
  - Abandons the transaction; no write is issued after reset is asserted and no resp_valid is produced.
  - A byte store reset in ACCESS leaves memory untouched.
- The downstream RAM has a synchronous reset that clears its contents; its reset must be driven by the same reset net.

Test Plan:
- Word store then load: store addr 0x010, data 0xBEEF -> write_rq pulses once with ram_wdata 0xBEEF; a following word load of 0x010 gives resp_rdata 0xBEEF, resp_valid 2 cycles after accept.
- Byte store preserves neighbour: word store 0x1234 at 0x020, then byte store 0xAB at 0x020 -> MERGE writes 0x12AB; word load gives 0x12AB; resp_valid 3 cycles after accept.
- Odd address: word store 0x5566 at 0x021 over a previous 0x1234 at 0x020 -> byte load 0x020 gives 0x0034, byte load 0x021 gives 0x0066, byte load 0x022 gives 0x0055.
- Top-address wrap: word store 0xA1B2 at 0x1FF -> byte load 0x1FF gives 0x00B2, byte load 0x000 gives 0x00A1.
- Handshake: hold req_valid high with changing addr during ACCESS/RESP -> only the latched request is executed; req_ready is 0 outside IDLE; exactly one resp_valid per accepted request.
- Reset mid byte store: assert reset during ACCESS -> all outputs 0 immediately, no write_rq; after release a load of that address returns the RAM reset value 0x0000.

Source files
------------

// File: rtl/ram16_access_ctrl.sv
// ram16_access_ctrl: turns CPU byte/word load/store requests into 16-bit RAM transactions, read-modify-write for byte stores
module ram16_access_ctrl #(
    parameter int addrSize = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_size,
    input  logic [addrSize-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    output logic                resp_valid,
    output logic [15:0]         resp_rdata,
    output logic [addrSize-1:0] ram_addr,
    output logic [15:0]         ram_wdata,
    output logic                ram_write_rq,
    output logic                ram_output_en,
    input  logic [15:0]         ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
    state_t state, state_nx;
    logic                we_q, size_q, word_wr;
    logic [addrSize-1:0] addr_q;
    logic [15:0]         wdata_q, rdata_q;
    logic [7:0]          old_hi;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            old_hi  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACCESS && !we_q)
                rdata_q <= size_q ? ram_rdata : {8'h00, ram_rdata[7:0]};
            // only the neighbour byte survives into the merged write
            if (state == ACCESS && we_q && !size_q)
                old_hi <= ram_rdata[15:8];
        end
    end
    always_comb begin
        state_nx      = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                        state == ACCESS ? ((we_q && !size_q) ? MERGE : RESP) :
                        state == MERGE  ? RESP : IDLE;
        word_wr       = state == ACCESS && we_q && size_q;
        req_ready     = reset && state == IDLE;
        ram_addr      = addr_q;
        ram_output_en = state == ACCESS || state == MERGE;
        ram_write_rq  = word_wr || state == MERGE;
        ram_wdata     = state == MERGE ? {old_hi, wdata_q[7:0]} : word_wr ? wdata_q : '0;
        resp_valid    = state == RESP;
        resp_rdata    = (state == RESP && we_q) ? '0 : rdata_q;
    end
endmodule
